// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver for the CPU's syscall value or fetch PC.
// The source is snapshotted once per scan frame, so a single frame never mixes old and new digits.
module seg7_scan_display #(
    parameter int CLK_DIV    = 100000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display_syscall,
    input  logic [14:0] display_pc,
    input  logic        mode,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_DIV - 1);
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    logic [PW-1:0] prescaler;
    logic [2:0]    digit_idx;
    logic [31:0]   shadow;
    logic          shadow_mode;
    logic          tick;
    logic          frame_load;
    logic [31:0]   src;
    logic [4:0]    shift_amt;
    logic [31:0]   upper;
    logic [3:0]    nibble;
    logic          blanked;
    logic [6:0]    seg_next;

    assign tick       = (prescaler == PRESCALE_LAST);
    assign frame_load = tick && (digit_idx == LAST_DIGIT);
    assign src        = mode ? {17'b0, display_pc} : display_syscall;

    // Scan timing plus the per-frame snapshot of the value and the mode it came from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler   <= '0;
            digit_idx   <= '0;
            shadow      <= '0;
            shadow_mode <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                digit_idx <= digit_idx + 3'd1;
            end
            if (frame_load) begin
                shadow      <= src;
                shadow_mode <= mode;
            end
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        shift_amt = {digit_idx, 2'b00};
        upper     = shadow >> shift_amt;
        nibble    = upper[3:0];
        blanked   = blank_lz && (digit_idx != 3'd0) && (upper == 32'd0);
        seg_next  = 7'h7F;
        if (!blanked) begin
            case (nibble)
                4'h0: seg_next = 7'h40;
                4'h1: seg_next = 7'h79;
                4'h2: seg_next = 7'h24;
                4'h3: seg_next = 7'h30;
                4'h4: seg_next = 7'h19;
                4'h5: seg_next = 7'h12;
                4'h6: seg_next = 7'h02;
                4'h7: seg_next = 7'h78;
                4'h8: seg_next = 7'h00;
                4'h9: seg_next = 7'h10;
                4'hA: seg_next = 7'h08;
                4'hB: seg_next = 7'h03;
                4'hC: seg_next = 7'h46;
                4'hD: seg_next = 7'h21;
                4'hE: seg_next = 7'h06;
                default: seg_next = 7'h0E;
            endcase
        end
    end

    // Registered outputs; the decimal point on digit 0 flags a PC snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= ~(8'd1 << digit_idx);
            seg        <= seg_next;
            dp         <= ~((digit_idx == 3'd0) && shadow_mode);
            frame_done <= frame_load;
        end
    end

endmodule
